// File: rtl/multi_debouncer_pkg.sv
// Shared types and helpers for the multi-channel debouncer.
// Optional long-press detection is enabled with MULTI_DEBOUNCER_LONG_PRESS_EN.
package multi_debouncer_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PUSH_WAIT    = 2'd1,
        PUSHED       = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam int unsigned US_PER_S = 1_000_000;
    localparam int unsigned MS_PER_S = 1_000;

    // Divide first so large clock rates do not overflow 32 bits.
    function automatic int unsigned cycles_for(input int unsigned clk_hz,
                                               input int unsigned units_per_s,
                                               input int unsigned amount);
        return (clk_hz / units_per_s) * amount;
    endfunction

endpackage

// File: rtl/debounce_ch.sv
// One debouncer channel: press/release FSM, stable-time counter, registered outputs.
// Hold counter and long-press pulse exist only with MULTI_DEBOUNCER_LONG_PRESS_EN.
module debounce_ch
    import multi_debouncer_pkg::*;
#(
    parameter int unsigned CNT_MAX  = 8,
    parameter int unsigned LONG_MAX = 1000
) (
    input  logic clk,
    input  logic n_rst,
    input  logic i_btn,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_long
);

    localparam int unsigned      CNT_W    = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

    if (LONG_MAX < 1) begin : g_long_chk
        $error("debounce_ch: LONG_MAX must be at least 1");
    end

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_press;
    logic             r_release;
    logic             w_enter_pushed;

    assign w_enter_pushed = (r_state == PUSH_WAIT) && i_btn && (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state   <= RELEASED;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            case (r_state)
                RELEASED: begin
                    if (i_btn) begin
                        r_state <= PUSH_WAIT;
                        r_cnt   <= '0;
                    end
                end
                PUSH_WAIT: begin
                    if (!i_btn) begin
                        r_state <= RELEASED;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= PUSHED;
                        r_cnt   <= '0;
                        r_level <= 1'b1;
                        r_press <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                PUSHED: begin
                    if (!i_btn) begin
                        r_state <= RELEASE_WAIT;
                        r_cnt   <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (i_btn) begin
                        r_state <= PUSHED;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state   <= RELEASED;
                        r_cnt     <= '0;
                        r_level   <= 1'b0;
                        r_release <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= RELEASED;
                    r_cnt   <= '0;
                    r_level <= 1'b0;
                end
            endcase
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;

`ifdef MULTI_DEBOUNCER_LONG_PRESS_EN
    localparam int unsigned       HOLD_W    = $clog2(LONG_MAX + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_MAX);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_MAX - 1);

    logic [HOLD_W-1:0] r_hold;
    logic              r_long;

    // Only a genuine new press clears the hold count; release bounces keep it.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_hold <= '0;
            r_long <= 1'b0;
        end else begin
            r_long <= 1'b0;
            if (w_enter_pushed) begin
                r_hold <= '0;
            end else if (((r_state == PUSHED) || (r_state == RELEASE_WAIT)) &&
                         (r_hold != HOLD_MAX)) begin
                r_hold <= r_hold + HOLD_W'(1);
                if (r_hold == HOLD_LAST) begin
                    r_long <= 1'b1;
                end
            end
        end
    end

    assign o_long = r_long;
`else
    logic w_unused;
    assign w_unused = w_enter_pushed;
    assign o_long   = 1'b0;
`endif

endmodule

// File: rtl/multi_debouncer.sv
// N-channel pushbutton debouncer: 2-FF synchroniser, polarity normalisation, per-channel FSMs.
// Define MULTI_DEBOUNCER_LONG_PRESS_EN to enable the btn_long pulse.
module multi_debouncer
    import multi_debouncer_pkg::*;
#(
    parameter int unsigned       NUM_CH          = 4,
    parameter int unsigned       CLK_FREQ_HZ     = 50_000_000,
    parameter int unsigned       DEBOUNCE_US     = 10_000,
    parameter logic [NUM_CH-1:0] ACTIVE_LOW_MASK = '0,
    parameter int unsigned       LONG_PRESS_MS   = 1_000
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic [NUM_CH-1:0] btn_raw,
    output logic [NUM_CH-1:0] btn_level,
    output logic [NUM_CH-1:0] btn_press,
    output logic [NUM_CH-1:0] btn_release,
    output logic [NUM_CH-1:0] btn_long
);

    localparam int unsigned CNT_MAX  = cycles_for(CLK_FREQ_HZ, US_PER_S, DEBOUNCE_US);
    localparam int unsigned LONG_MAX = cycles_for(CLK_FREQ_HZ, MS_PER_S, LONG_PRESS_MS);

    if (CNT_MAX < 2) begin : g_cnt_chk
        $error("multi_debouncer: CNT_MAX must be at least 2");
    end

    logic [NUM_CH-1:0] r_sync1;
    logic [NUM_CH-1:0] r_sync2;
    logic [NUM_CH-1:0] w_b;

    // Reset to the idle polarity so every channel sees "not pressed" on reset exit.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_sync1 <= ACTIVE_LOW_MASK;
            r_sync2 <= ACTIVE_LOW_MASK;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_b = r_sync2 ^ ACTIVE_LOW_MASK;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        debounce_ch #(
            .CNT_MAX  (CNT_MAX),
            .LONG_MAX (LONG_MAX)
        ) u_ch (
            .clk       (clk),
            .n_rst     (n_rst),
            .i_btn     (w_b[i]),
            .o_level   (btn_level[i]),
            .o_press   (btn_press[i]),
            .o_release (btn_release[i]),
            .o_long    (btn_long[i])
        );
    end

endmodule

// File: tb/tb_multi_debouncer.sv
// Directed self-checking bench for multi_debouncer (CNT_MAX=8, LONG_MAX=1000, ch3 active-low).
// Long-press expectations follow MULTI_DEBOUNCER_LONG_PRESS_EN.
module tb_multi_debouncer;

`ifdef MULTI_DEBOUNCER_LONG_PRESS_EN
    localparam logic [3:0] EXP_LONG = 4'b0001;
`else
    localparam logic [3:0] EXP_LONG = 4'b0000;
`endif

    logic       clk = 1'b0;
    logic       n_rst;
    logic [3:0] btn_raw;
    logic [3:0] btn_level;
    logic [3:0] btn_press;
    logic [3:0] btn_release;
    logic [3:0] btn_long;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    multi_debouncer #(
        .NUM_CH          (4),
        .CLK_FREQ_HZ     (1_000_000),
        .DEBOUNCE_US     (8),
        .ACTIVE_LOW_MASK (4'b1000),
        .LONG_PRESS_MS   (1)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_long    (btn_long)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance n edges, collecting OR of pulses/level and AND of level.
    task automatic run(input int n,
                       output logic [3:0] p_or, output logic [3:0] r_or,
                       output logic [3:0] l_or, output logic [3:0] lv_or,
                       output logic [3:0] lv_and);
        p_or = '0; r_or = '0; l_or = '0; lv_or = '0; lv_and = '1;
        for (int i = 0; i < n; i++) begin
            step();
            p_or   |= btn_press;
            r_or   |= btn_release;
            l_or   |= btn_long;
            lv_or  |= btn_level;
            lv_and &= btn_level;
        end
    endtask

    logic [3:0] p, r, l, lvo, lva;
    logic [3:0] p_acc, r_acc, l_acc, lva_acc;

    initial begin
        n_rst   = 1'b0;
        btn_raw = 4'b1000;
        repeat (3) step();
        check("rst_level",   btn_level,   4'b0000);
        check("rst_press",   btn_press,   4'b0000);
        check("rst_release", btn_release, 4'b0000);
        check("rst_long",    btn_long,    4'b0000);

        // Reset exit with active-low ch3 idle high: nothing happens
        n_rst = 1'b1;
        run(20, p, r, l, lvo, lva);
        check("idle_press", p, 4'b0000);
        check("idle_rel",   r, 4'b0000);
        check("idle_level", lvo, 4'b0000);

        // Clean press on ch0
        btn_raw[0] = 1'b1;
        run(10, p, r, l, lvo, lva);
        check("s1_nopress_early", p, 4'b0000);
        check("s1_nolevel_early", lvo, 4'b0000);
        step();
        check("s1_level_e11", btn_level, 4'b0001);
        check("s1_press_e11", btn_press, 4'b0001);
        step();
        check("s1_press_e12", btn_press, 4'b0000);

        // Press bounce on ch1: 5 high, 1 low, then steady
        btn_raw[1] = 1'b1;
        run(5, p, r, l, lvo, lva);
        p_acc = p;
        btn_raw[1] = 1'b0;
        run(1, p, r, l, lvo, lva);
        p_acc |= p;
        btn_raw[1] = 1'b1;
        run(10, p, r, l, lvo, lva);
        p_acc |= p;
        check("s2_nopress_bounce", p_acc, 4'b0000);
        step();
        check("s2_press_e11", btn_press, 4'b0010);
        check("s2_level",     btn_level, 4'b0011);

        // Release ch0 with high glitches
        btn_raw[0] = 1'b0;
        run(4, p, r, l, lvo, lva);
        r_acc = r; lva_acc = lva;
        btn_raw[0] = 1'b1;
        run(3, p, r, l, lvo, lva);
        r_acc |= r; lva_acc &= lva;
        btn_raw[0] = 1'b0;
        run(2, p, r, l, lvo, lva);
        r_acc |= r; lva_acc &= lva;
        btn_raw[0] = 1'b1;
        run(3, p, r, l, lvo, lva);
        r_acc |= r; lva_acc &= lva;
        btn_raw[0] = 1'b0;
        run(10, p, r, l, lvo, lva);
        r_acc |= r; lva_acc &= lva;
        check("s3_norel_early",  r_acc, 4'b0000);
        check("s3_level_held",   lva_acc[0], 1'b1);
        step();
        check("s3_rel_e11",   btn_release, 4'b0001);
        check("s3_level_e11", btn_level,   4'b0010);
        run(10, p, r, l, lvo, lva);
        check("s3_rel_once", r, 4'b0000);

        // Active-low ch3 and ch0 pressed in the same cycle
        btn_raw[3] = 1'b0;
        btn_raw[0] = 1'b1;
        run(10, p, r, l, lvo, lva);
        check("s4_nopress_early", p, 4'b0000);
        step();
        check("s4_press_e11", btn_press, 4'b1001);
        check("s4_level",     btn_level, 4'b1011);

        // Reset during ch2 PUSH_WAIT
        btn_raw[2] = 1'b1;
        run(6, p, r, l, lvo, lva);
        check("s5_nopress_wait", p, 4'b0000);
        n_rst = 1'b0;
        #1;
        check("s5_async_clear", {btn_level, btn_press, btn_release, btn_long}, 16'h0000);
        step();
        step();
        n_rst = 1'b1;
        run(10, p, r, l, lvo, lva);
        check("s5_nopress_early", p, 4'b0000);
        check("s5_nolevel_early", lvo, 4'b0000);
        check("s5_norel_exit",    r, 4'b0000);
        step();
        check("s5_press_e11", btn_press, 4'b1111);
        check("s5_level_e11", btn_level, 4'b1111);

        // Release everything
        btn_raw = 4'b1000;
        run(10, p, r, l, lvo, lva);
        check("s5_norel_early", r, 4'b0000);
        step();
        check("s5_rel_e11",   btn_release, 4'b1111);
        check("s5_level_rel", btn_level,   4'b0000);

        // Long press on ch0
        btn_raw[0] = 1'b1;
        run(10, p, r, l, lvo, lva);
        step();
        check("s6_press", btn_press, 4'b0001);
        run(999, p, r, l, lvo, lva);
        check("s6_nolong_early", l, 4'b0000);
        step();
        check("s6_long", btn_long, EXP_LONG);
        step();
        check("s6_long_off", btn_long, 4'b0000);

        // Release bounce back to PUSHED must not re-arm the long pulse
        btn_raw[0] = 1'b0;
        run(3, p, r, l, lvo, lva);
        l_acc = l; r_acc = r; p_acc = p;
        btn_raw[0] = 1'b1;
        run(1010, p, r, l, lvo, lva);
        l_acc |= l; r_acc |= r; p_acc |= p;
        check("s6_nolong_bounce", l_acc, 4'b0000);
        check("s6_norel_bounce",  r_acc, 4'b0000);
        check("s6_nopress_bounce", p_acc, 4'b0000);
        check("s6_level_bounce",  lva[0], 1'b1);

        btn_raw[0] = 1'b0;
        run(30, p, r, l, lvo, lva);
        check("s6_nolong_rel", l, 4'b0000);
        check("s6_rel",        r, 4'b0001);
        check("s6_level_end",  btn_level, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
